// File: rtl/mipi_bayer_frame_sequencer.sv
// Frame sequencer between the MIPI RAW10 depacker and the Bayer demosaic:
// tracks row/column, polices line length and appends zero pad lines to drain the demosaic.
module mipi_bayer_frame_sequencer #(
    parameter int Image_width = 1920,
    parameter int Image_Higth = 1080,
    parameter int Pixel_Num   = 4,
    parameter int Col_Max     = Image_width / Pixel_Num,
    parameter int I_w         = Pixel_Num * 10,
    parameter int Pad_Lines   = 2,
    parameter int Pad_Gap     = 16
) (
    input  logic           I_CLK,
    input  logic           I_Rst,
    input  logic           I_Mipi_Unpacket_V_sync,
    input  logic [I_w-1:0] I_Mipi_raw10_depacker_Data,
    input  logic           I_Mipi_raw10_depacker_Vaild,
    output logic           O_Bayer_V_sync,
    output logic [I_w-1:0] O_Bayer_Data,
    output logic           O_Bayer_Vaild,
    output logic           O_Pixel_flag,
    output logic [15:0]    O_Row_Cnt,
    output logic           O_Frame_Done,
    output logic           O_Err_Short_Line,
    output logic           O_Err_Long_Line,
    output logic           O_Busy
);

    localparam int Row_Max = Image_Higth + Pad_Lines;
    localparam int Col_W   = (Col_Max > 1) ? $clog2(Col_Max) : 1;
    localparam int Row_W   = (Row_Max > 1) ? $clog2(Row_Max) : 1;
    localparam int Gap_W   = (Pad_Gap > 1) ? $clog2(Pad_Gap) : 1;

    localparam logic [Col_W-1:0] COL_LAST = Col_W'(Col_Max - 1);
    localparam logic [Row_W-1:0] ROW_PAD0 = Row_W'(Image_Higth);
    localparam logic [Row_W-1:0] ROW_LAST = Row_W'(Row_Max - 1);
    localparam logic [Gap_W-1:0] GAP_LAST = Gap_W'(Pad_Gap - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_PAD_GAP  = 2'd2;
    localparam logic [1:0] ST_PAD_LINE = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [Col_W-1:0] col, col_nxt;
    logic [Row_W-1:0] row, row_nxt;
    logic [Gap_W-1:0] gap_cnt, gap_nxt;
    logic             line_full, line_full_nxt;
    logic             vld_p0;
    logic             done_p1, done_nxt;
    logic             fwd, fwd_flag, vs_nxt;
    logic [I_w-1:0]   fwd_data;
    logic             err_short_nxt, err_long_nxt;

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        gap_nxt       = gap_cnt;
        line_full_nxt = line_full;
        fwd           = 1'b0;
        fwd_flag      = 1'b0;
        fwd_data      = '0;
        vs_nxt        = 1'b0;
        done_nxt      = 1'b0;
        err_short_nxt = O_Err_Short_Line;
        err_long_nxt  = O_Err_Long_Line;

        if (I_Mipi_Unpacket_V_sync) begin
            // Frame start wins over everything; a coincident word becomes col 0 of row 0
            state_nxt     = ST_ACTIVE;
            col_nxt       = '0;
            row_nxt       = '0;
            line_full_nxt = 1'b0;
            err_short_nxt = 1'b0;
            err_long_nxt  = 1'b0;
            vs_nxt        = 1'b1;
            if (I_Mipi_raw10_depacker_Vaild) begin
                fwd      = 1'b1;
                fwd_data = I_Mipi_raw10_depacker_Data;
                if (COL_LAST == '0) line_full_nxt = 1'b1;
                else                col_nxt       = Col_W'(1);
            end
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (I_Mipi_raw10_depacker_Vaild) begin
                        if (line_full) begin
                            err_long_nxt = 1'b1;
                        end else begin
                            fwd      = 1'b1;
                            fwd_data = I_Mipi_raw10_depacker_Data;
                            fwd_flag = row[0];
                            if (col == COL_LAST) begin
                                col_nxt       = '0;
                                line_full_nxt = 1'b1;
                            end else begin
                                col_nxt = col + Col_W'(1);
                            end
                        end
                    end else if (vld_p0 && (line_full || col != '0)) begin
                        // Burst just ended; a partial line still consumes a row
                        if (!line_full) err_short_nxt = 1'b1;
                        line_full_nxt = 1'b0;
                        col_nxt       = '0;
                        row_nxt       = row + Row_W'(1);
                        if (row_nxt == ROW_PAD0) begin
                            state_nxt = ST_PAD_GAP;
                            gap_nxt   = '0;
                        end
                    end
                end
                ST_PAD_GAP: begin
                    if (I_Mipi_raw10_depacker_Vaild) err_long_nxt = 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = ST_PAD_LINE;
                        col_nxt   = '0;
                    end else begin
                        gap_nxt = gap_cnt + Gap_W'(1);
                    end
                end
                ST_PAD_LINE: begin
                    if (I_Mipi_raw10_depacker_Vaild) err_long_nxt = 1'b1;
                    fwd      = 1'b1;
                    fwd_flag = row[0];
                    if (col == COL_LAST) begin
                        col_nxt = '0;
                        if (row == ROW_LAST) begin
                            row_nxt   = '0;
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            row_nxt   = row + Row_W'(1);
                            state_nxt = ST_PAD_GAP;
                            gap_nxt   = '0;
                        end
                    end else begin
                        col_nxt = col + Col_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register stage: data, valid and parity lag the input by one cycle
    always_ff @(posedge I_CLK) begin
        if (I_Rst) begin
            state            <= ST_IDLE;
            col              <= '0;
            row              <= '0;
            gap_cnt          <= '0;
            line_full        <= 1'b0;
            vld_p0           <= 1'b0;
            done_p1          <= 1'b0;
            O_Bayer_V_sync   <= 1'b0;
            O_Bayer_Data     <= '0;
            O_Bayer_Vaild    <= 1'b0;
            O_Pixel_flag     <= 1'b0;
            O_Row_Cnt        <= '0;
            O_Frame_Done     <= 1'b0;
            O_Err_Short_Line <= 1'b0;
            O_Err_Long_Line  <= 1'b0;
            O_Busy           <= 1'b0;
        end else begin
            state            <= state_nxt;
            col              <= col_nxt;
            row              <= row_nxt;
            gap_cnt          <= gap_nxt;
            line_full        <= line_full_nxt;
            vld_p0           <= I_Mipi_raw10_depacker_Vaild;
            done_p1          <= done_nxt;
            O_Bayer_V_sync   <= vs_nxt;
            O_Bayer_Data     <= fwd_data;
            O_Bayer_Vaild    <= fwd;
            O_Pixel_flag     <= fwd_flag;
            O_Row_Cnt        <= 16'(row_nxt);
            O_Frame_Done     <= done_p1;
            O_Err_Short_Line <= err_short_nxt;
            O_Err_Long_Line  <= err_long_nxt;
            O_Busy           <= (state_nxt != ST_IDLE);
        end
    end

endmodule
